// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core data port, the fetch requester and the external
// memory bus. The arbiter takes the master side; the core/memory environment takes slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              d_read;
  logic              d_write;
  logic              d_read_done;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_busy;
  logic              mem_ready;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_data;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  d_read, d_write, d_read_done, d_addr, d_wdata,
    input  f_req, f_addr,
    input  bus_ack, bus_rdata,
    output d_rdata, mem_busy, mem_ready,
    output f_ack, f_data,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output d_read, d_write, d_read_done, d_addr, d_wdata,
    output f_req, f_addr,
    output bus_ack, bus_rdata,
    input  d_rdata, mem_busy, mem_ready,
    input  f_ack, f_data,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the external memory bus between the core data port (busy/ready stall
// handshake) and a fetch requester, sequencing each access with a req/ack protocol.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master io
);

  typedef enum logic [2:0] {IDLE, D_RD, D_WR, D_HOLD, F_RD} state_t;
  typedef enum logic {GRANT_DATA, GRANT_FETCH} grant_t;

  state_t            r_state;
  state_t            w_next;
  grant_t            r_last_grant;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] r_f_data;
  logic              r_f_ack;

  logic              w_f_pending;
  logic              w_busy;
  logic              w_take_rd;
  logic              w_take_wr;
  logic              w_take_f;

  // f_req is masked while f_ack is high so a held request is serviced only once.
  // After a data grant a pending fetch makes the data port look busy for one IDLE cycle.
  always_comb begin
    w_f_pending = io.f_req & ~r_f_ack;
    w_busy      = (r_state inside {D_RD, D_WR, F_RD}) ||
                  ((r_state == IDLE) && w_f_pending && (r_last_grant == GRANT_DATA));
    w_take_rd   = (r_state == IDLE) && !w_busy && io.d_read;
    w_take_wr   = (r_state == IDLE) && !w_busy && !io.d_read && io.d_write;
    w_take_f    = (r_state == IDLE) && !w_take_rd && !w_take_wr && w_f_pending;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take_rd)      w_next = D_RD;
        else if (w_take_wr) w_next = D_WR;
        else if (w_take_f)  w_next = F_RD;
      end
      D_RD:    if (io.bus_ack)     w_next = D_HOLD;
      D_WR:    if (io.bus_ack)     w_next = IDLE;
      F_RD:    if (io.bus_ack)     w_next = IDLE;
      D_HOLD:  if (io.d_read_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GRANT_FETCH;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_d_rdata    <= '0;
      r_f_data     <= '0;
      r_f_ack      <= 1'b0;
    end else begin
      r_f_ack <= 1'b0;
      if (w_take_rd) begin
        r_bus_req    <= 1'b1;
        r_bus_we     <= 1'b0;
        r_bus_addr   <= io.d_addr;
        r_last_grant <= GRANT_DATA;
      end
      if (w_take_wr) begin
        r_bus_req    <= 1'b1;
        r_bus_we     <= 1'b1;
        r_bus_addr   <= io.d_addr;
        r_bus_wdata  <= io.d_wdata;
        r_last_grant <= GRANT_DATA;
      end
      if (w_take_f) begin
        r_bus_req    <= 1'b1;
        r_bus_we     <= 1'b0;
        r_bus_addr   <= io.f_addr;
        r_last_grant <= GRANT_FETCH;
      end
      // r_bus_req is only set in the bus states, so a stray ack is ignored here.
      if (r_bus_req && io.bus_ack) begin
        r_bus_req <= 1'b0;
        if (r_state == D_RD) begin
          r_d_rdata <= io.bus_rdata;
        end
        if (r_state == F_RD) begin
          r_f_data <= io.bus_rdata;
          r_f_ack  <= 1'b1;
        end
      end
    end
  end

  assign io.mem_busy  = w_busy;
  assign io.mem_ready = (r_state == D_HOLD);
  assign io.d_rdata   = r_d_rdata;
  assign io.f_ack     = r_f_ack;
  assign io.f_data    = r_f_data;
  assign io.bus_req   = r_bus_req;
  assign io.bus_we    = r_bus_we;
  assign io.bus_addr  = r_bus_addr;
  assign io.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: decoder/fetch/bus models, a vector table of data accesses,
// and scoreboard queues for expected bus accesses, load data and fetch data.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned waits;
    int unsigned hold;
    logic        exp_we;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   f_ack_cnt;

  bus_t        exp_bus[$];
  logic [15:0] exp_d[$];
  logic [15:0] exp_f[$];

  int unsigned wait_cfg;
  bit          slave_en;
  logic        s_ack;
  logic [15:0] s_rdata;
  logic        man_ack;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bif)
  );

  assign bif.bus_ack   = slave_en ? s_ack : man_ack;
  assign bif.bus_rdata = slave_en ? s_rdata : 16'h9999;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mdl(input logic [15:0] a);
    if (a == 16'h1234) return 16'hBEEF;
    return {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic push_bus(input logic we, input logic [15:0] a, input logic [15:0] wd);
    bus_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    exp_bus.push_back(e);
  endtask

  // Bus slave: acks after wait_cfg wait cycles and checks each access against the scoreboard.
  initial begin
    int unsigned wcnt;
    bus_t e;
    wcnt = 0; s_ack = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      if (!slave_en) begin
        s_ack = 1'b0; wcnt = 0;
      end else if (s_ack) begin
        s_ack = 1'b0;
      end else if (bif.bus_req) begin
        if (wcnt >= wait_cfg) begin
          s_ack = 1'b1;
          s_rdata = bif.bus_we ? 16'h0000 : mdl(bif.bus_addr);
          wcnt = 0;
          if (exp_bus.size() == 0) begin
            fail_now("bus_unexpected_access");
          end else begin
            e = exp_bus.pop_front();
            chk("bus_we", bif.bus_we, e.we);
            chk("bus_addr", bif.bus_addr, e.addr);
            if (e.we) chk("bus_wdata", bif.bus_wdata, e.wdata);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Output monitor: load data on mem_ready entry (then held), fetch data on f_ack.
  initial begin
    logic        prev_rdy;
    logic [15:0] held;
    prev_rdy = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (bif.f_ack) begin
        f_ack_cnt++;
        if (exp_f.size() == 0) fail_now("f_ack_unexpected");
        else chk("f_data", bif.f_data, exp_f.pop_front());
      end
      if (bif.mem_ready && !prev_rdy) begin
        if (exp_d.size() == 0) fail_now("mem_ready_unexpected");
        else chk("d_rdata", bif.d_rdata, exp_d.pop_front());
        held = bif.d_rdata;
      end else if (bif.mem_ready) begin
        chk("d_rdata_hold", bif.d_rdata, held);
      end
      prev_rdy = bif.mem_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // Decoder: present a request at a negedge, hold it until accepted, drop it after the edge.
  task automatic dec_issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    int n;
    n = 0;
    bif.d_read = rd; bif.d_write = wr; bif.d_addr = a; bif.d_wdata = wd;
    #1;
    while ((bif.mem_busy || bif.mem_ready) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 500) fail_now("dec_accept_timeout");
    @(posedge clk); #1;
    bif.d_read = 1'b0; bif.d_write = 1'b0;
    bif.d_addr = 16'($urandom); bif.d_wdata = 16'($urandom);
  endtask

  task automatic dec_finish_load(input int unsigned hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!bif.mem_ready && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) fail_now("mem_ready_timeout");
    repeat (hold) @(negedge clk);
    bif.d_read_done = 1'b1;
    @(negedge clk);
    bif.d_read_done = 1'b0;
    chk("mem_ready_drop", bif.mem_ready, 1'b0);
  endtask

  task automatic fetch_wait();
    int n;
    n = 0;
    while (!bif.f_ack && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) fail_now("f_ack_timeout");
    bif.f_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus_req"},   bif.bus_req,   1'b0);
    chk({tag, "_bus_we"},    bif.bus_we,    1'b0);
    chk({tag, "_bus_addr"},  bif.bus_addr,  16'h0);
    chk({tag, "_bus_wdata"}, bif.bus_wdata, 16'h0);
    chk({tag, "_d_rdata"},   bif.d_rdata,   16'h0);
    chk({tag, "_f_data"},    bif.f_data,    16'h0);
    chk({tag, "_f_ack"},     bif.f_ack,     1'b0);
    chk({tag, "_mem_busy"},  bif.mem_busy,  1'b0);
    chk({tag, "_mem_ready"}, bif.mem_ready, 1'b0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] wd, input int unsigned w, input int unsigned h);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.waits = w; v.hold = h;
    v.exp_we = !rd && wr;
    v.exp_rdata = mdl(a);
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    int   f_before;

    vecs[0] = mk(1'b1, 1'b0, 16'h1234, 16'h0000, 2, 2);
    vecs[1] = mk(1'b0, 1'b1, 16'h0010, 16'h55AA, 1, 0);
    vecs[2] = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0);
    vecs[3] = mk(1'b1, 1'b1, 16'h00F0, 16'hDEAD, 1, 0);
    vecs[4] = mk(1'b0, 1'b1, 16'hABCD, 16'h1357, 3, 0);
    vecs[5] = mk(1'b0, 1'b1, 16'h0002, 16'h2468, 0, 0);
    vecs[6] = mk(1'b1, 1'b1, 16'h4321, 16'hFFFF, 0, 1);
    vecs[7] = mk(1'b1, 1'b0, 16'hFFFF, 16'h0000, 3, 0);

    vectors = 0; miscompares = 0; f_ack_cnt = 0;
    wait_cfg = 0; slave_en = 1'b1; man_ack = 1'b0;
    rst_n = 1'b0;
    bif.d_read = 1'b0; bif.d_write = 1'b0; bif.d_read_done = 1'b0;
    bif.d_addr = '0; bif.d_wdata = '0; bif.f_req = 1'b0; bif.f_addr = '0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Zero-wait load latency: grant in cycle 0, bus_req in 1, mem_ready in 2, IDLE in 3.
    @(negedge clk);
    wait_cfg = 0;
    push_bus(1'b0, 16'h0040, 16'h0);
    exp_d.push_back(mdl(16'h0040));
    bif.d_read = 1'b1; bif.d_addr = 16'h0040;
    #1 chk("ld_c0_busy", bif.mem_busy, 1'b0);
    @(negedge clk);
    bif.d_read = 1'b0;
    chk("ld_c1_bus_req", bif.bus_req, 1'b1);
    chk("ld_c1_bus_we", bif.bus_we, 1'b0);
    chk("ld_c1_busy", bif.mem_busy, 1'b1);
    @(negedge clk);
    chk("ld_c2_ready", bif.mem_ready, 1'b1);
    bif.d_read_done = 1'b1;
    @(negedge clk);
    bif.d_read_done = 1'b0;
    chk("ld_c3_ready", bif.mem_ready, 1'b0);
    chk("ld_c3_bus_req", bif.bus_req, 1'b0);

    // Posted store with two bus wait cycles: busy spans the access up to and including the ack cycle.
    wait_cfg = 2;
    push_bus(1'b1, 16'h0010, 16'h55AA);
    dec_issue(1'b0, 1'b1, 16'h0010, 16'h55AA);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (bif.mem_busy && n < 20) begin
        n++; @(negedge clk);
      end
      chk("store_busy_cycles", n, 3);
    end

    for (int i = 0; i < 8; i++) begin
      wait_cfg = vecs[i].waits;
      push_bus(vecs[i].exp_we, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].exp_we) exp_d.push_back(vecs[i].exp_rdata);
      dec_issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].exp_we) dec_finish_load(vecs[i].hold);
      else @(negedge clk);
    end

    // Contention at reset release: data first, then the blocked IDLE grants the fetch once.
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    wait_cfg = 1;
    bif.f_req = 1'b1; bif.f_addr = 16'h0F00;
    push_bus(1'b0, 16'h2000, 16'h0);
    push_bus(1'b0, 16'h0F00, 16'h0);
    exp_d.push_back(mdl(16'h2000));
    exp_f.push_back(mdl(16'h0F00));
    f_before = f_ack_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      begin
        dec_issue(1'b1, 1'b0, 16'h2000, 16'h0);
        dec_finish_load(0);
        chk("fair_block_busy", bif.mem_busy, 1'b1);
      end
      fetch_wait();
    join
    repeat (3) @(negedge clk);
    chk("contention_f_ack_pulses", f_ack_cnt - f_before, 1);
    chk("contention_no_regrant", bif.bus_req, 1'b0);

    // Back-to-back loads with a held fetch: order data, fetch, data.
    wait_cfg = 0;
    bif.f_req = 1'b1; bif.f_addr = 16'h0F10;
    push_bus(1'b0, 16'h3000, 16'h0);
    push_bus(1'b0, 16'h0F10, 16'h0);
    push_bus(1'b0, 16'h3002, 16'h0);
    exp_d.push_back(mdl(16'h3000));
    exp_d.push_back(mdl(16'h3002));
    exp_f.push_back(mdl(16'h0F10));
    f_before = f_ack_cnt;
    fork
      begin
        dec_issue(1'b1, 1'b0, 16'h3000, 16'h0);
        dec_finish_load(1);
        dec_issue(1'b1, 1'b0, 16'h3002, 16'h0);
        dec_finish_load(0);
      end
      fetch_wait();
    join
    chk("b2b_f_ack_pulses", f_ack_cnt - f_before, 1);

    // Reset in the middle of a load, then a late ack with bus_req low.
    @(negedge clk);
    slave_en = 1'b0;
    bif.d_read = 1'b1; bif.d_addr = 16'h7777;
    @(negedge clk);
    bif.d_read = 1'b0;
    chk("midrst_bus_req", bif.bus_req, 1'b1);
    chk("midrst_bus_addr", bif.bus_addr, 16'h7777);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("late_ack_ready", bif.mem_ready, 1'b0);
    chk("late_ack_f_ack", bif.f_ack, 1'b0);
    chk("late_ack_bus_req", bif.bus_req, 1'b0);
    repeat (2) @(negedge clk);
    chk("late_ack_ready2", bif.mem_ready, 1'b0);
    chk("late_ack_d_rdata", bif.d_rdata, 16'h0);
    slave_en = 1'b1;

    repeat (2) @(negedge clk);
    chk("exp_bus_drained", exp_bus.size(), 0);
    chk("exp_d_drained", exp_d.size(), 0);
    chk("exp_f_drained", exp_f.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory bus between the core's data port (load/store handshake driven by the instruction decoder) and a fetch/auxiliary requester. It owns the `mem_busy` / `mem_ready` stall handshake the decoder uses for ldd/ldo/std/sto. It sequences each access on the external bus with a req/ack protocol. It sits between the core and the memory switcher.

## Interface
Parameters:
- ADDR_W, 16, address width of both requesters and the bus
- DATA_W, 16, data width

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_read  in  1  decoder load request (ram_read)
- d_write  in  1  decoder store request (ram_write), posted
- d_read_done  in  1  decoder consumed load data (ram_read_done)
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  latched load data, valid while mem_ready
- mem_busy  out  1  data port cannot accept; decoder stalls
- mem_ready  out  1  load data available
- f_req  in  1  fetch request, held until f_ack
- f_addr  in  ADDR_W  fetch address
- f_ack  out  1  one-cycle completion pulse
- f_data  out  DATA_W  fetch data, valid with f_ack
- bus_req  out  1  bus access request, held until bus_ack
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  bus completion; read data valid the same cycle
- bus_rdata  in  DATA_W  bus read data

## Operation
- States: IDLE, D_RD, D_WR, D_HOLD, F_RD. One last_grant bit (DATA/FETCH).
- mem_busy is combinational:
  - 1 in D_RD, D_WR, F_RD.
  - 1 in IDLE when f_req=1, f_ack=0 and last_grant=DATA. This is the fairness block.
  - 0 otherwise.
- mem_ready = 1 only in D_HOLD.
- IDLE, mem_busy=0:
  - d_read → D_RD. Capture d_addr, bus_we=0.
  - d_write → D_WR. Capture d_addr/d_wdata, bus_we=1.
  - d_read and d_write together → read wins.
  - Taking either data branch sets last_grant=DATA. The data port always wins here, because the decoder treats "not busy" as accepted.
- IDLE, no data request, or mem_busy=1: f_req & ~f_ack → F_RD. Capture f_addr, set last_grant=FETCH.
- Data requests while mem_busy=1 are ignored; the decoder re-presents them.
- D_RD, D_WR, F_RD: bus_req=1 with stable addr/we/wdata until bus_ack is sampled high.
  - D_RD on ack: latch bus_rdata → d_rdata, go to D_HOLD.
  - D_WR on ack: go to IDLE.
  - F_RD on ack: latch bus_rdata → f_data, pulse f_ack for the next cycle, go to IDLE.
- D_HOLD: d_rdata held, d_read/d_write/f_req ignored. d_read_done=1 → IDLE.
- bus_ack while bus_req=0 is ignored.
- f_req is masked during the f_ack cycle, so one request yields exactly one access.

## Timing
- bus_req, bus_we, bus_addr, bus_wdata, f_ack, f_data, d_rdata are all registered.
- Load, zero-wait bus:
  - cycle 0: IDLE, d_read
  - cycle 1: bus_req=1, bus_ack=1
  - cycle 2: mem_ready=1, d_read_done
  - cycle 3: IDLE
- Each wait cycle on bus_ack adds one cycle.
- Store: accepted in cycle 0, decoder advances. mem_busy=1 from cycle 1 until the cycle after bus_ack.
- Fetch: f_req sampled in cycle 0, bus_req in cycle 1, f_ack pulse in the cycle after bus_ack.
- Back-to-back: D_WR → IDLE → a new grant is possible in that IDLE cycle. There is no dead cycle besides IDLE itself.
- Starvation bound: with f_req pending, at most one data access is granted before the fetch.
- Reset values, applied asynchronously and mid-transaction included:
  - state=IDLE, last_grant=FETCH
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0
  - d_rdata=0, f_data=0, f_ack=0
  - mem_busy=0, mem_ready=0
  - An in-flight access is abandoned; a late bus_ack is ignored.

## Test plan
- Load: d_read, d_addr=0x1234, bus_ack 2 cycles after bus_req with rdata=0xBEEF → bus_addr=0x1234, bus_we=0; mem_ready=1 with d_rdata=0xBEEF until d_read_done, then IDLE next cycle.
- Posted store: d_write, addr=0x0010, wdata=0x55AA; d_addr changes next cycle → bus_addr/bus_wdata stay 0x0010/0x55AA; mem_busy=1 until the cycle after bus_ack.
- Contention: f_req and d_read both asserted at reset release → data served first. The next IDLE shows mem_busy=1 and grants the fetch. f_ack is a single pulse and f_req is not re-granted.
- Back-to-back loads with f_req held → order is data, fetch, data. No requester waits more than one foreign access.
- Reset mid-D_RD with bus_req=1 → all outputs take reset values immediately; a bus_ack arriving after reset produces no mem_ready or f_ack.
- Simultaneous d_read and d_write → single read access (bus_we=0); no write is issued.
